// File: rtl/dest_reg_arbiter_pkg.sv
// Shared defaults and FSM encoding for the destination register file arbiter.
package dest_reg_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_I_WIDTH = 4;
    localparam int DEF_D_WIDTH = 16;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/dest_reg_arbiter_if.sv
// Requester handshakes plus the register-file port, seen from the requesters (master)
// and from the arbiter (slave).
interface dest_reg_arbiter_if
    import dest_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int I_WIDTH = DEF_I_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) ();

    // Handshake: a requester holds req with its fields until it sees gnt; the access
    // takes effect at the clock edge that ends the grant cycle, after which req may drop.
    logic [NUM_REQ-1:0]         wr_req;
    logic [NUM_REQ*I_WIDTH-1:0] wr_idx;
    logic [NUM_REQ*D_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]         wr_gnt;
    logic                       rd_req;
    logic [I_WIDTH-1:0]         rd_idx;
    logic                       rd_gnt;
    logic                       rd_valid;
    logic [D_WIDTH-1:0]         rd_data;
    logic                       clr_start;
    logic                       clr_busy;
    logic                       clr_done;
    logic [I_WIDTH-1:0]         reg_index;
    logic                       reg_w_en;
    logic                       reg_r_en;
    logic [D_WIDTH-1:0]         reg_wdata;
    logic [D_WIDTH-1:0]         reg_rdata;

    modport master (
        output wr_req, wr_idx, wr_data, rd_req, rd_idx, clr_start, reg_rdata,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, clr_busy, clr_done,
        input  reg_index, reg_w_en, reg_r_en, reg_wdata
    );

    modport slave (
        input  wr_req, wr_idx, wr_data, rd_req, rd_idx, clr_start, reg_rdata,
        output wr_gnt, rd_gnt, rd_valid, rd_data, clr_busy, clr_done,
        output reg_index, reg_w_en, reg_r_en, reg_wdata
    );

endinterface

// File: rtl/dest_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts one past the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            logic [PW-1:0] j;
            j = PW'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[j]) begin
                o_gnt[j] = 1'b1;
                w_win    = j;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= PW'(N - 1);
        end else if (i_en && w_found) begin
            r_ptr <= w_win;
        end
    end

endmodule

// File: rtl/dest_reg_arbiter.sv
// Shares a single-port register file between NUM_REQ write-back requesters and one reader,
// and zero-fills the whole file on request.
module dest_reg_arbiter
    import dest_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int I_WIDTH = DEF_I_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    dest_reg_arbiter_if.slave   bus,
    output state_t              o_state
);

    localparam logic [I_WIDTH-1:0] LAST_IDX = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [I_WIDTH-1:0] r_clr_cnt;
    logic               r_last_was_rd;
    logic               r_rd_valid;
    logic               r_clr_done;

    logic               w_serve;
    logic               w_rd_gnt;
    logic               w_wr_allow;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_wr_gnt;
    logic [I_WIDTH-1:0] w_win_idx;
    logic [D_WIDTH-1:0] w_win_data;

    // Gating on rst keeps every grant and enable low during an asynchronous reset.
    assign w_serve    = rst && (r_state == SERVE);
    assign w_rd_gnt   = w_serve && bus.rd_req && !(r_last_was_rd && (|bus.wr_req));
    assign w_wr_allow = w_serve && !w_rd_gnt;
    assign w_arb_req  = w_wr_allow ? bus.wr_req : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_arb_req),
        .i_en  (w_wr_allow),
        .o_gnt (w_wr_gnt)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_wr_gnt[k]) begin
                w_win_idx  = bus.wr_idx[k*I_WIDTH +: I_WIDTH];
                w_win_data = bus.wr_data[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    always_comb begin
        bus.reg_w_en  = 1'b0;
        bus.reg_r_en  = 1'b0;
        bus.reg_index = '0;
        bus.reg_wdata = '0;
        if (rst && (r_state == CLEAR)) begin
            bus.reg_w_en  = 1'b1;
            bus.reg_index = r_clr_cnt;
        end else if (w_rd_gnt) begin
            bus.reg_r_en  = 1'b1;
            bus.reg_index = bus.rd_idx;
        end else if (|w_wr_gnt) begin
            bus.reg_w_en  = 1'b1;
            bus.reg_index = w_win_idx;
            bus.reg_wdata = w_win_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SERVE:   if (bus.clr_start) w_next_state = CLEAR;
            CLEAR:   if (r_clr_cnt == LAST_IDX) w_next_state = SERVE;
            default: w_next_state = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= SERVE;
            r_clr_cnt     <= '0;
            r_last_was_rd <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_clr_done    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_last_was_rd <= w_rd_gnt;
            r_rd_valid    <= w_rd_gnt;
            r_clr_done    <= (r_state == CLEAR) && (r_clr_cnt == LAST_IDX);
            if (r_state == CLEAR) begin
                r_clr_cnt <= (r_clr_cnt == LAST_IDX) ? '0 : r_clr_cnt + 1'b1;
            end
        end
    end

    assign bus.wr_gnt   = w_wr_gnt;
    assign bus.rd_gnt   = w_rd_gnt;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_valid ? bus.reg_rdata : '0;
    assign bus.clr_busy = (r_state == CLEAR);
    assign bus.clr_done = r_clr_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_dest_reg_arbiter.sv
// Directed bench for dest_reg_arbiter with a behavioural 1-cycle-read register file.
module tb_dest_reg_arbiter;
    import dest_reg_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int IW = 4;
    localparam int DW = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;

    dest_reg_arbiter_if #(.NUM_REQ(NR), .I_WIDTH(IW), .D_WIDTH(DW)) bus ();

    dest_reg_arbiter #(.NUM_REQ(NR), .I_WIDTH(IW), .D_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, registered read, zero when not returning data.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q;
    logic          rd_q_v;

    always @(posedge clk) begin
        if (bus.reg_w_en) mem[bus.reg_index] <= bus.reg_wdata;
        rd_q_v <= bus.reg_r_en;
        if (bus.reg_r_en) rd_q <= mem[bus.reg_index];
    end
    assign bus.reg_rdata = rd_q_v ? rd_q : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_req    = '0;
        bus.wr_idx    = '0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_idx    = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_write(input int k, input logic [IW-1:0] idx, input logic [DW-1:0] d);
        logic [NR-1:0] e_gnt;
        e_gnt = NR'(1) << k;
        @(negedge clk);
        bus.wr_req = e_gnt;
        bus.wr_idx[k*IW +: IW]  = idx;
        bus.wr_data[k*DW +: DW] = d;
        #1;
        check("wr_gnt", 32'(bus.wr_gnt), 32'(e_gnt));
        check("wr_w_en", 32'(bus.reg_w_en), 32'd1);
        check("wr_index", 32'(bus.reg_index), 32'(idx));
        check("wr_wdata", 32'(bus.reg_wdata), 32'(d));
        @(posedge clk);
        #1;
        bus.wr_req = '0;
    endtask

    task automatic do_read(input logic [IW-1:0] idx, input logic [DW-1:0] exp);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        #1;
        check("rd_gnt", 32'(bus.rd_gnt), 32'd1);
        check("rd_r_en", 32'(bus.reg_r_en), 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        check("rd_valid", 32'(bus.rd_valid), 32'd1);
        check("rd_data", 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] e_gnt;
        logic [IW-1:0] ii;

        // Reset: requests present but everything held low.
        idle_inputs();
        bus.wr_req = 4'b1111;
        bus.rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
        check("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
        check("rst_w_en", 32'(bus.reg_w_en), 32'd0);
        check("rst_r_en", 32'(bus.reg_r_en), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(SERVE));
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("idle_w_en", 32'(bus.reg_w_en), 32'd0);
        check("idle_r_en", 32'(bus.reg_r_en), 32'd0);
        check("idle_index", 32'(bus.reg_index), 32'd0);
        check("idle_wdata", 32'(bus.reg_wdata), 32'd0);

        // 1: write then read back.
        do_write(0, 4'd3, 16'h1234);
        do_read(4'd3, 16'h1234);

        // 2: all four requesters, dropping on grant; order 0..3 twice.
        do_reset();
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            bus.wr_req = 4'b1111;
            for (int k = 0; k < NR; k++) begin
                bus.wr_idx[k*IW +: IW]  = IW'(4 + k);
                bus.wr_data[k*DW +: DW] = DW'(16'hA000 + k);
            end
            for (int c = 0; c < NR; c++) begin
                e_gnt = NR'(1) << c;
                @(negedge clk);
                check("t2_wr_gnt", 32'(bus.wr_gnt), 32'(e_gnt));
                @(posedge clk);
                #1;
                bus.wr_req[c] = 1'b0;
            end
        end

        // 3: read and write2 held together alternate, read first.
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'd3;
        bus.wr_req = 4'b0100;
        bus.wr_idx[2*IW +: IW]  = 4'd5;
        bus.wr_data[2*DW +: DW] = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t3_rd_gnt", 32'(bus.rd_gnt), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("t3_wr_gnt", 32'(bus.wr_gnt), (c % 2 == 0) ? 32'd0 : 32'h4);
            check("t3_rd_valid", 32'(bus.rd_valid), (c % 2 == 1) ? 32'd1 : 32'd0);
            check("t3_rd_data", 32'(bus.rd_data), (c % 2 == 1) ? 32'h1234 : 32'd0);
        end
        @(posedge clk);
        #1;
        idle_inputs();

        // 4+5: fill, clear with a read in the start cycle and a write pending during the sweep.
        do_reset();
        for (int i = 0; i < 16; i++) do_write(0, IW'(i), 16'hFFFF);
        bus.clr_start = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'd2;
        @(negedge clk);
        check("t4_start_rd_gnt", 32'(bus.rd_gnt), 32'd1);
        check("t4_start_busy", 32'(bus.clr_busy), 32'd0);
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        bus.rd_req = 1'b0;
        check("t4_first_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t4_first_rd_data", 32'(bus.rd_data), 32'hFFFF);
        bus.wr_req = 4'b0010;
        bus.wr_idx[1*IW +: IW]  = 4'd9;
        bus.wr_data[1*DW +: DW] = 16'h5A5A;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("t4_busy", 32'(bus.clr_busy), 32'd1);
            check("t4_wr_gnt", 32'(bus.wr_gnt), 32'd0);
            check("t4_rd_gnt", 32'(bus.rd_gnt), 32'd0);
            check("t4_w_en", 32'(bus.reg_w_en), 32'd1);
            check("t4_index", 32'(bus.reg_index), 32'(c));
            check("t4_wdata", 32'(bus.reg_wdata), 32'd0);
            check("t4_clr_done", 32'(bus.clr_done), 32'd0);
            bus.clr_start = (c == 5);
        end
        @(negedge clk);
        check("t5_clr_done", 32'(bus.clr_done), 32'd1);
        check("t5_busy", 32'(bus.clr_busy), 32'd0);
        check("t5_wr_gnt", 32'(bus.wr_gnt), 32'h2);
        check("t5_index", 32'(bus.reg_index), 32'd9);
        check("t5_wdata", 32'(bus.reg_wdata), 32'h5A5A);
        @(posedge clk);
        #1;
        bus.wr_req = '0;
        @(negedge clk);
        check("t5_clr_done_once", 32'(bus.clr_done), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(SERVE));
        for (int i = 0; i < 16; i++) begin
            ii = IW'(i);
            do_read(ii, (i == 9) ? 16'h5A5A : 16'h0000);
        end

        // 6: reset while the sweep is at index 7.
        for (int i = 0; i < 16; i++) do_write(1, IW'(i), 16'hFFFF);
        bus.clr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t6_index7", 32'(bus.reg_index), 32'd7);
        #1;
        rst = 1'b0;
        #1;
        check("t6_busy", 32'(bus.clr_busy), 32'd0);
        check("t6_w_en", 32'(bus.reg_w_en), 32'd0);
        check("t6_r_en", 32'(bus.reg_r_en), 32'd0);
        check("t6_index", 32'(bus.reg_index), 32'd0);
        check("t6_state", 32'(dbg_state), 32'(SERVE));
        check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_clr_done", 32'(bus.clr_done), 32'd0);
            check("t6_still_serve", 32'(bus.clr_busy), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            ii = IW'(i);
            do_read(ii, (i < 7) ? 16'h0000 : 16'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
